// File: rtl/mc_pkg.sv
// mc_pkg: shared types for the multicycle controller.
// Holds the state enumeration, opcode constants, datapath select encodings,
// the control-word struct and the Moore decode from state to control word.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    EXEC_I = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12,
    FAULT  = 4'd13
  } state_t;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] HLT   = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       halted;
    logic       fault;
  } ctl_t;

  // Per-state control word. The FETCH irwrite/pcwrite pulse depends on
  // mem_ready and is added by the top level, so it is 0 here.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALU_ADD;
        c.pcsource = PC_ALU;
      end
      DECODE: begin
        c.alusrcb = SRCB_SHIMM;
        c.aluop   = ALU_ADD;
      end
      MEMADR, EXEC_I: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      EXEC_R: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALU_FUNCT;
      end
      RWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      IWB: c.regwrite = 1'b1;
      BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_REG;
        c.aluop       = ALU_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PC_ALUOUT;
      end
      JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PC_JUMP;
      end
      HALT:    c.halted = 1'b1;
      FAULT:   c.fault  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting for mem_ready in a memory state.
// Ports: clk/reset (async high), active = FSM is in a memory state,
//        ready = mem_ready, expired = limit reached with no ready this cycle.
module mc_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Every memory state exits on ready or on expiry, and the count is held at
  // zero outside memory states, so each entry starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || ready || cnt == LIMIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ready in the limit cycle takes priority over expiry.
  assign expired = active && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath.
// Ports: clk, reset (async high), opcode, mem_ready in; datapath strobes,
//        selects, halted, fault and debug state out.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       irwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state
);

  state_t cur;
  state_t nxt;
  ctl_t   ctl;
  logic   wait_st;
  logic   expired;
  logic   fetch_go;

  assign wait_st = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);

  mc_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .active (wait_st),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH: begin
        if (mem_ready)    nxt = DECODE;
        else if (expired) nxt = FAULT;
      end
      DECODE: begin
        case (opcode)
          RTYPE:       nxt = EXEC_R;
          ADDI, ADDIU: nxt = EXEC_I;
          LW, SW:      nxt = MEMADR;
          BEQ:         nxt = BRANCH;
          J:           nxt = JUMP;
          HLT:         nxt = HALT;
          default:     nxt = FAULT;
        endcase
      end
      // opcode is re-sampled here; anything but lw/sw is treated as undefined.
      MEMADR: begin
        if (opcode == LW)      nxt = MEMRD;
        else if (opcode == SW) nxt = MEMWR;
        else                   nxt = FAULT;
      end
      MEMRD: begin
        if (mem_ready)    nxt = MEMWB;
        else if (expired) nxt = FAULT;
      end
      MEMWR: begin
        if (mem_ready)    nxt = FETCH;
        else if (expired) nxt = FAULT;
      end
      EXEC_R:  nxt = RWB;
      EXEC_I:  nxt = IWB;
      MEMWB, RWB, IWB, BRANCH, JUMP: nxt = FETCH;
      HALT:    nxt = HALT;
      FAULT:   nxt = FAULT;
      default: nxt = FAULT;
    endcase
  end

  // Control word is registered alongside the state so outputs are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= FETCH;
      ctl <= ctl_of(FETCH);
    end else begin
      cur <= nxt;
      ctl <= ctl_of(nxt);
    end
  end

  // The instruction-register load and PC increment happen only in the cycle
  // the fetch completes, and never while reset is held.
  assign fetch_go = (cur == FETCH) && mem_ready && !reset;

  assign pcwrite     = ctl.pcwrite | fetch_go;
  assign irwrite     = ctl.irwrite | fetch_go;
  assign pcwritecond = ctl.pcwritecond;
  assign iord        = ctl.iord;
  assign memread     = ctl.memread;
  assign memwrite    = ctl.memwrite;
  assign memtoreg    = ctl.memtoreg;
  assign regdst      = ctl.regdst;
  assign regwrite    = ctl.regwrite;
  assign alusrca     = ctl.alusrca;
  assign alusrcb     = ctl.alusrcb;
  assign aluop       = ctl.aluop;
  assign pcsource    = ctl.pcsource;
  assign halted      = ctl.halted;
  assign fault       = ctl.fault;
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scenario bench for multicycle_control (TIMEOUT=4).
// Expected state/output words are queued as stimulus is driven and popped
// when the DUT outputs are sampled on the falling edge.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, irwrite, memread, memwrite;
  logic       memtoreg, regdst, regwrite, alusrca, halted, fault;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int checks = 0;
  int fails  = 0;
  logic [21:0] exp_q[$];

  localparam logic [5:0] JUNK = 6'b010101;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .halted(halted), .fault(fault), .state(state)
  );

  wire logic [17:0] outv = {pcwrite, pcwritecond, iord, irwrite, memread,
                            memwrite, memtoreg, regdst, regwrite, alusrca,
                            alusrcb, aluop, pcsource, halted, fault};

  // Reference output table, written independently from the design.
  function automatic logic [17:0] exp_vec(input state_t st, input logic rdy);
    logic pcw, pcwc, io, irw, mrd, mwr, m2r, rdst, rw, sa, hl, fl;
    logic [1:0] sb, ao, ps;
    {pcw, pcwc, io, irw, mrd, mwr, m2r, rdst, rw, sa, hl, fl} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      FETCH:  begin mrd = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      DECODE: sb = 2'b11;
      MEMADR: begin sa = 1; sb = 2'b10; end
      MEMRD:  begin mrd = 1; io = 1; end
      MEMWR:  begin mwr = 1; io = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      EXEC_R: begin sa = 1; ao = 2'b10; end
      RWB:    begin rdst = 1; rw = 1; end
      EXEC_I: begin sa = 1; sb = 2'b10; end
      IWB:    rw = 1;
      BRANCH: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
      JUMP:   begin pcw = 1; ps = 2'b10; end
      HALT:   hl = 1;
      FAULT:  fl = 1;
      default: ;
    endcase
    return {pcw, pcwc, io, irw, mrd, mwr, m2r, rdst, rw, sa, sb, ao, ps, hl, fl};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, sample at negedge.
  task automatic cyc(input string nm, input logic [5:0] op, input logic rdy,
                     input state_t st);
    logic [21:0] e;
    opcode = op;
    mem_ready = rdy;
    exp_q.push_back({4'(st), exp_vec(st, rdy)});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (state !== e[21:18]) begin
      fails++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, e[21:18]);
    end
    checks++;
    if (outv !== e[17:0]) begin
      fails++;
      $display("FAIL %s outputs: got %b expected %b", nm, outv, e[17:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = HLT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'(FETCH)) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", state, FETCH);
    end
    checks++;
    if (outv !== exp_vec(FETCH, 1'b0)) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", outv, exp_vec(FETCH, 1'b0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_rtype();
    cyc("r_fetch",  JUNK,  1, FETCH);
    cyc("r_decode", RTYPE, 1, DECODE);
    cyc("r_exec",   JUNK,  1, EXEC_R);
    cyc("r_wb",     JUNK,  0, RWB);
    cyc("r_next",   JUNK,  0, FETCH);
  endtask

  task automatic test_lw();
    cyc("lw_fetch",  JUNK, 0, FETCH);
    cyc("lw_fetch",  JUNK, 1, FETCH);
    cyc("lw_decode", LW,   0, DECODE);
    cyc("lw_adr",    LW,   1, MEMADR);
    for (int i = 0; i < 3; i++) cyc("lw_wait", JUNK, 0, MEMRD);
    cyc("lw_rd",     JUNK, 1, MEMRD);
    cyc("lw_wb",     JUNK, 1, MEMWB);
    cyc("lw_next",   JUNK, 1, FETCH);
  endtask

  // Opcode changed between DECODE and MEMADR: MEMADR's sample decides.
  task automatic test_sw_and_misc();
    cyc("sw_decode", LW,   0, DECODE);
    cyc("sw_adr",    SW,   0, MEMADR);
    cyc("sw_wait",   JUNK, 0, MEMWR);
    cyc("sw_wr",     JUNK, 1, MEMWR);
    cyc("i_fetch",   JUNK, 1, FETCH);
    cyc("i_decode",  ADDIU,0, DECODE);
    cyc("i_exec",    JUNK, 0, EXEC_I);
    cyc("i_wb",      JUNK, 0, IWB);
    cyc("b_fetch",   JUNK, 1, FETCH);
    cyc("b_decode",  BEQ,  0, DECODE);
    cyc("b_branch",  JUNK, 1, BRANCH);
    cyc("j_fetch",   JUNK, 1, FETCH);
    cyc("j_decode",  J,    0, DECODE);
    cyc("j_jump",    JUNK, 0, JUMP);
    cyc("a_fetch",   JUNK, 1, FETCH);
    cyc("a_decode",  ADDI, 0, DECODE);
    cyc("a_exec",    JUNK, 0, EXEC_I);
    cyc("a_wb",      JUNK, 0, IWB);
    cyc("a_next",    JUNK, 0, FETCH);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) cyc("to_wait", JUNK, 0, FETCH);
    for (int i = 0; i < 6; i++) cyc("to_fault", 6'(i), 1'(i), FAULT);
    do_reset();
  endtask

  task automatic test_ready_at_limit();
    for (int i = 0; i < 4; i++) cyc("lim_wait", JUNK, 0, FETCH);
    cyc("lim_fetch", JUNK, 1, FETCH);
    cyc("lim_decode", LW,  0, DECODE);
    cyc("lim_adr",   LW,   0, MEMADR);
    for (int i = 0; i < 4; i++) cyc("lim_rdwait", JUNK, 0, MEMRD);
    cyc("lim_rd",    JUNK, 1, MEMRD);
    cyc("lim_wb",    JUNK, 0, MEMWB);
    cyc("lim_next",  JUNK, 1, FETCH);
  endtask

  task automatic test_halt();
    cyc("h_decode", HLT, 1, DECODE);
    for (int i = 0; i < 20; i++) cyc("h_hold", 6'(i), 1'(i % 2), HALT);
    do_reset();
    cyc("h_after", JUNK, 0, FETCH);
  endtask

  task automatic test_undef_and_midwrite_reset();
    cyc("u_fetch",  JUNK, 1, FETCH);
    cyc("u_decode", 6'b000011, 0, DECODE);
    cyc("u_fault",  RTYPE, 1, FAULT);
    do_reset();
    cyc("m_fetch",  JUNK, 1, FETCH);
    cyc("m_decode", SW,   0, DECODE);
    cyc("m_adr",    SW,   0, MEMADR);
    cyc("m_wait",   JUNK, 0, MEMWR);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'(FETCH) || memwrite !== 1'b0) begin
      fails++;
      $display("FAIL midwrite_reset: got state %0d memwrite %b expected %0d 0",
               state, memwrite, FETCH);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cyc("m_after", JUNK, 1, FETCH);
    cyc("m_dec2",  RTYPE, 0, DECODE);
  endtask

  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_sw_and_misc();
    test_timeout();
    test_ready_at_limit();
    test_halt();
    test_undef_and_midwrite_reset();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles any memory state waits for mem_ready before faulting; legal range 1..255.
REQ-002 Parameter: CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  6  instruction opcode field, taken from the instruction register.
REQ-006 mem_ready  input  1  memory completion handshake for the current access.
REQ-007 pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg, regdst, regwrite, alusrca  output  1 each  datapath strobes and mux selects.
REQ-008 alusrcb, aluop, pcsource  output  2 each  ALU B-select (00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm), ALU op class (00 add, 01 sub, 10 funct), PC source (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 halted  output  1  high while in HALT.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 state  output  4  current state encoding, for debug.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, HALT, FAULT.
REQ-013 Outputs are a Moore function of state only; every output not listed for a state is 0.
REQ-014 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-015 FETCH: irwrite=1 and pcwrite=1 only in the cycle mem_ready=1; that cycle, next state is DECODE.
REQ-016 DECODE: alusrca=0, alusrcb=11, aluop=00; next state per opcode: 000000->EXEC_R; 001000 or 001001->EXEC_I; 100011 or 101011->MEMADR; 000100->BRANCH; 000010->JUMP; 111111->HALT; any other opcode->FAULT.
REQ-017 EXEC_R: alusrca=1, alusrcb=00, aluop=10; next state RWB.
REQ-018 RWB: regdst=1, regwrite=1, memtoreg=0; next state FETCH.
REQ-019 EXEC_I: alusrca=1, alusrcb=10, aluop=00; next state IWB.
REQ-020 IWB: regdst=0, regwrite=1, memtoreg=0; next state FETCH.
REQ-021 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD for lw, MEMWR for sw.
REQ-022 MEMRD: memread=1, iord=1; advances to MEMWB when mem_ready=1.
REQ-023 MEMWR: memwrite=1, iord=1; advances to FETCH when mem_ready=1.
REQ-024 MEMWB: regdst=0, regwrite=1, memtoreg=1; next state FETCH.
REQ-025 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; next state FETCH.
REQ-026 JUMP: pcwrite=1, pcsource=10; next state FETCH.
REQ-027 HALT and FAULT are absorbing and leave them only on reset; all strobes are 0 in both.
REQ-028 Wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle spent in that state with mem_ready=0.
REQ-029 When the counter equals TIMEOUT with mem_ready=0, the next state is FAULT.
REQ-030 mem_ready in the same cycle the counter reaches TIMEOUT wins; the state advances normally.
REQ-031 mem_ready is ignored in all non-memory states.
REQ-032 opcode is sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Reset
REQ-033 Asserting reset forces state=FETCH and counter=0 immediately, independent of clk, including in the middle of a memory wait, HALT or FAULT.
REQ-034 While reset is high, outputs take FETCH values except pcwrite=0 and irwrite=0; halted=0; fault=0.
REQ-035 The first FETCH access begins on the first rising clk edge after reset deasserts.

Structure
REQ-036 A shared package mc_pkg holds the state enumeration, the opcode constants (RTYPE, ADDI, ADDIU, LW, SW, BEQ, J, HLT) and the aluop, alusrcb and pcsource encodings.
REQ-037 One sub-module, mc_wait_timer, holds the CNT_W-bit counter and timeout compare, with TIMEOUT as its parameter.

Verification
REQ-038 R-type, mem_ready=1 in FETCH -> state sequence FETCH, DECODE, EXEC_R, RWB, FETCH (4 cycles); regwrite=1 only in RWB; aluop=10 in EXEC_R.
REQ-039 lw with mem_ready low for 3 cycles in MEMRD -> memread=1 and iord=1 held for 4 cycles; exactly one regwrite, with memtoreg=1, in MEMWB.
REQ-040 TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 waiting cycles; fault=1; state unchanged thereafter until reset.
REQ-041 opcode 111111 -> HALT; halted=1; all strobes 0 for 20 cycles; reset -> FETCH.
REQ-042 Undefined opcode 000011 -> FAULT; reset asserted mid-MEMWR -> state=FETCH immediately with memwrite=0.
REQ-043 mem_ready=1 in the exact cycle the counter equals TIMEOUT -> normal advance, no fault.
